readout_rx_bin_integrator: RTL and testbench
============================================

READOUT_RX_BIN_INTEGRATOR -- requirements
Module: readout_rx_bin_integrator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of signed I/Q in and out.
REQ-002 SHALL have parameter BIN_LEN_WIDTH, default 8, width of the samples-per-bin config.
REQ-003 SHALL have parameter NUM_BIN_WIDTH, default 8, width of the bins-per-measurement config.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port cfg_bin_len, input, BIN_LEN_WIDTH, samples per bin (0 treated as 1).
REQ-007 SHALL have port cfg_num_bins, input, NUM_BIN_WIDTH, bins per measurement (0 treated as 1).
REQ-008 SHALL have port cfg_shift, input, 4, arithmetic right shift applied to each bin sum.
REQ-009 SHALL have port meas_start, input, 1, single-cycle pulse that opens a measurement window.
REQ-010 SHALL have port valid_in, input, 1, qualifies i_in and q_in.
REQ-011 SHALL have ports i_in and q_in, input, DATA_WIDTH signed each, demodulated samples.
REQ-012 SHALL have port valid_out, output, 1, qualifies i_out and q_out (feeds state-decision valid_in).
REQ-013 SHALL have ports i_out and q_out, output, DATA_WIDTH signed each, integrated bin values.
REQ-014 SHALL have port start_count_out, output, 1, asserted with the first bin's valid_out.
REQ-015 SHALL have port finish_count_out, output, 1, single-cycle pulse one cycle after the last bin's valid_out.
REQ-016 SHALL have port busy, output, 1, high while not in IDLE.
REQ-017 SHALL have port err_restart, output, 1, sticky; set by meas_start while busy.

Function
REQ-018 SHALL implement FSM IDLE -> INTEG (on meas_start) -> DONE (last bin emitted) -> IDLE (next cycle).
REQ-019 SHALL latch cfg_bin_len, cfg_num_bins and cfg_shift on meas_start; config changes mid-window have no effect.
REQ-020 SHALL accumulate i_in/q_in in ACC_WIDTH = DATA_WIDTH+BIN_LEN_WIDTH signed accumulators, only on valid_in in INTEG.
REQ-021 SHALL close a bin on the valid sample that makes the sample count equal bin_len, restarting the accumulator from 0 that cycle.
REQ-022 SHALL register valid_out, i_out and q_out one cycle after the closing sample (latency 1).
REQ-023 SHALL compute output as the sum arithmetically right-shifted by cfg_shift, then reduced to DATA_WIDTH per REQ-036.
REQ-024 SHALL count emitted bins; after bin num_bins emits, FSM enters DONE and pulses finish_count_out the cycle after that valid_out.
REQ-025 SHALL ignore valid_in in IDLE and DONE; samples gaps (valid_in low) do not advance counters.
REQ-026 SHALL ignore meas_start while busy and set err_restart; meas_start in the DONE cycle is also ignored.
REQ-027 SHALL hold valid_out, start_count_out and finish_count_out low except in their defined cycles.

Reset
REQ-028 SHALL, on rst low, immediately force FSM to IDLE, clear counters and accumulators, and drive all outputs 0.
REQ-029 SHALL, on reset mid-window, drop the partial bin and emit no finish_count_out.
REQ-030 SHALL clear err_restart only by reset.

Configuration
REQ-031 SHALL use macro READOUT_RX_BIN_INTEGRATOR_SAT_EN.
REQ-032 SHALL, with the macro defined, saturate the shifted sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-033 SHALL, without the macro, truncate the shifted sum to its low DATA_WIDTH bits (two's-complement wrap).

Structure
REQ-034 SHALL place FSM state encoding and the ACC_WIDTH derivation in the shared readout_rx define header/package.
REQ-035 SHALL contain one sub-module, readout_rx_iq_shift_sat, instantiated once for I and once for Q.
REQ-036 SHALL keep readout_rx_iq_shift_sat combinational, shift and saturate/truncate per REQ-031..033.

Verification
REQ-037 SHALL test basic window: bin_len=4, num_bins=2, shift=2, eight samples I=100, Q=-100 -> two valid_out with I=100, Q=-100; start_count_out on first; finish_count_out 1 cycle after second.
REQ-038 SHALL test gaps: bin_len=3 with valid_in pattern 1,0,1,0,0,1, I=1 -> one valid_out I=3>>shift, emitted 1 cycle after the third valid.
REQ-039 SHALL test saturation: bin_len=4, shift=0, I=30000 -> I_out=32767 with macro, 120000 mod 2^16 (=-11072) without.
REQ-040 SHALL test restart: meas_start during INTEG -> window continues unchanged, err_restart=1 until reset.
REQ-041 SHALL test async reset mid-bin: rst low for 1 cycle after 2 of 4 samples -> outputs 0 at once, no finish pulse, busy=0.
REQ-042 SHALL test zero config: cfg_bin_len=0, cfg_num_bins=0 -> one bin per valid sample, one bin total, then finish pulse.

Source files
------------

// File: rtl/readout_rx_bin_integrator_pkg.sv
// Shared definitions for the readout RX bin integrator: FSM state encoding and
// accumulator width derivation.
package readout_rx_bin_integrator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INTEG = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_e;

  localparam int SHIFT_WIDTH = 4;

  // Accumulator must hold 2^BIN_LEN_WIDTH full-scale samples without overflow.
  function automatic int acc_width(input int data_w, input int bin_len_w);
    return data_w + bin_len_w;
  endfunction

endpackage

// File: rtl/readout_rx_bin_integrator_iq_shift_sat.sv
// Combinational bin-sum reduction: arithmetic right shift, then saturate
// (READOUT_RX_BIN_INTEGRATOR_SAT_EN defined) or wrap to DATA_WIDTH bits.
module readout_rx_iq_shift_sat
  import readout_rx_bin_integrator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic signed [ACC_WIDTH-1:0]   sum_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  output logic signed [DATA_WIDTH-1:0]  val_o
);

  logic signed [ACC_WIDTH-1:0] shifted;

  assign shifted = sum_i >>> shift_i;

`ifdef READOUT_RX_BIN_INTEGRATOR_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Clamp to the representable output range.
  always_comb begin
    if (shifted > SAT_MAX) begin
      val_o = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      val_o = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      val_o = shifted[DATA_WIDTH-1:0];
    end
  end
`else
  logic unused_hi_bits;

  assign unused_hi_bits = ^shifted[ACC_WIDTH-1:DATA_WIDTH];
  assign val_o          = shifted[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/readout_rx_bin_integrator.sv
// Integrates demodulated I/Q samples into bins over a measurement window.
// Optional output saturation: define READOUT_RX_BIN_INTEGRATOR_SAT_EN.
module readout_rx_bin_integrator
  import readout_rx_bin_integrator_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int BIN_LEN_WIDTH = 8,
  parameter int NUM_BIN_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic        [BIN_LEN_WIDTH-1:0] cfg_bin_len,
  input  logic        [NUM_BIN_WIDTH-1:0] cfg_num_bins,
  input  logic        [SHIFT_WIDTH-1:0]   cfg_shift,
  input  logic                            meas_start,
  input  logic                            valid_in,
  input  logic signed [DATA_WIDTH-1:0]    i_in,
  input  logic signed [DATA_WIDTH-1:0]    q_in,
  output logic                            valid_out,
  output logic signed [DATA_WIDTH-1:0]    i_out,
  output logic signed [DATA_WIDTH-1:0]    q_out,
  output logic                            start_count_out,
  output logic                            finish_count_out,
  output logic                            busy,
  output logic                            err_restart
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, BIN_LEN_WIDTH);

  localparam logic [BIN_LEN_WIDTH-1:0] BL_ZERO = {BIN_LEN_WIDTH{1'b0}};
  localparam logic [BIN_LEN_WIDTH-1:0] BL_ONE  = {{(BIN_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NUM_BIN_WIDTH-1:0] NB_ZERO = {NUM_BIN_WIDTH{1'b0}};
  localparam logic [NUM_BIN_WIDTH-1:0] NB_ONE  = {{(NUM_BIN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH-1:0]     ACC_ZERO = {ACC_WIDTH{1'b0}};

  rx_state_e                   state_q, state_d;
  logic [BIN_LEN_WIDTH-1:0]    bin_len_q, bin_len_d;
  logic [NUM_BIN_WIDTH-1:0]    num_bins_q, num_bins_d;
  logic [SHIFT_WIDTH-1:0]      shift_q, shift_d;
  logic [BIN_LEN_WIDTH-1:0]    smp_cnt_q, smp_cnt_d;
  logic [NUM_BIN_WIDTH-1:0]    bin_cnt_q, bin_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
  logic                        valid_q, valid_d;
  logic signed [DATA_WIDTH-1:0] i_out_q, i_out_d;
  logic signed [DATA_WIDTH-1:0] q_out_q, q_out_d;
  logic                        start_q, start_d;
  logic                        finish_q, finish_d;
  logic                        err_q, err_d;

  logic signed [ACC_WIDTH-1:0]  sum_i, sum_q;
  logic signed [DATA_WIDTH-1:0] red_i, red_q;
  logic [BIN_LEN_WIDTH-1:0]     smp_cnt_inc;
  logic [NUM_BIN_WIDTH-1:0]     bin_cnt_inc;
  logic                         take_smp;
  logic                         bin_close;
  logic                         last_bin;

  // The closing sample is part of its bin, so reduce acc+sample, not acc.
  assign sum_i       = acc_i_q + ACC_WIDTH'(i_in);
  assign sum_q       = acc_q_q + ACC_WIDTH'(q_in);
  assign smp_cnt_inc = smp_cnt_q + BL_ONE;
  assign bin_cnt_inc = bin_cnt_q + NB_ONE;
  assign take_smp    = (state_q == ST_INTEG) && valid_in;
  assign bin_close   = take_smp && (smp_cnt_inc == bin_len_q);
  assign last_bin    = bin_close && (bin_cnt_inc == num_bins_q);

  readout_rx_iq_shift_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_shift_sat_i (
    .sum_i   (sum_i),
    .shift_i (shift_q),
    .val_o   (red_i)
  );

  readout_rx_iq_shift_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_shift_sat_q (
    .sum_i   (sum_q),
    .shift_i (shift_q),
    .val_o   (red_q)
  );

  // Next-state and datapath update for the window FSM.
  always_comb begin
    state_d    = state_q;
    bin_len_d  = bin_len_q;
    num_bins_d = num_bins_q;
    shift_d    = shift_q;
    smp_cnt_d  = smp_cnt_q;
    bin_cnt_d  = bin_cnt_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    valid_d    = 1'b0;
    i_out_d    = i_out_q;
    q_out_d    = q_out_q;
    start_d    = 1'b0;
    finish_d   = 1'b0;

    if (meas_start && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (meas_start) begin
          bin_len_d  = (cfg_bin_len == BL_ZERO) ? BL_ONE : cfg_bin_len;
          num_bins_d = (cfg_num_bins == NB_ZERO) ? NB_ONE : cfg_num_bins;
          shift_d    = cfg_shift;
          smp_cnt_d  = BL_ZERO;
          bin_cnt_d  = NB_ZERO;
          acc_i_d    = ACC_ZERO;
          acc_q_d    = ACC_ZERO;
          state_d    = ST_INTEG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INTEG: begin
        if (bin_close) begin
          acc_i_d   = ACC_ZERO;
          acc_q_d   = ACC_ZERO;
          smp_cnt_d = BL_ZERO;
          bin_cnt_d = bin_cnt_inc;
          valid_d   = 1'b1;
          i_out_d   = red_i;
          q_out_d   = red_q;
          start_d   = (bin_cnt_q == NB_ZERO);
          state_d   = last_bin ? ST_DONE : ST_INTEG;
        end else if (take_smp) begin
          acc_i_d   = sum_i;
          acc_q_d   = sum_q;
          smp_cnt_d = smp_cnt_inc;
        end else begin
          state_d = ST_INTEG;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        finish_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bin_len_q  <= BL_ZERO;
      num_bins_q <= NB_ZERO;
      shift_q    <= {SHIFT_WIDTH{1'b0}};
      smp_cnt_q  <= BL_ZERO;
      bin_cnt_q  <= NB_ZERO;
      acc_i_q    <= ACC_ZERO;
      acc_q_q    <= ACC_ZERO;
      valid_q    <= 1'b0;
      i_out_q    <= {DATA_WIDTH{1'b0}};
      q_out_q    <= {DATA_WIDTH{1'b0}};
      start_q    <= 1'b0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_len_q  <= bin_len_d;
      num_bins_q <= num_bins_d;
      shift_q    <= shift_d;
      smp_cnt_q  <= smp_cnt_d;
      bin_cnt_q  <= bin_cnt_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      valid_q    <= valid_d;
      i_out_q    <= i_out_d;
      q_out_q    <= q_out_d;
      start_q    <= start_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
    end
  end

  assign valid_out        = valid_q;
  assign i_out            = i_out_q;
  assign q_out            = q_out_q;
  assign start_count_out  = start_q;
  assign finish_count_out = finish_q;
  assign busy             = (state_q != ST_IDLE);
  assign err_restart      = err_q;

endmodule

// File: tb/tb_readout_rx_bin_integrator.sv
// Self-checking bench for readout_rx_bin_integrator: directed scenarios with
// literal expectations plus randomized windows against a behavioural model.
module tb_readout_rx_bin_integrator;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [7:0]         cfg_bin_len = 8'd0;
  logic [7:0]         cfg_num_bins = 8'd0;
  logic [3:0]         cfg_shift = 4'd0;
  logic               meas_start = 1'b0;
  logic               valid_in = 1'b0;
  logic signed [15:0] i_in = 16'sd0;
  logic signed [15:0] q_in = 16'sd0;
  logic               valid_out;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               start_count_out;
  logic               finish_count_out;
  logic               busy;
  logic               err_restart;

  readout_rx_bin_integrator dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_bin_len      (cfg_bin_len),
    .cfg_num_bins     (cfg_num_bins),
    .cfg_shift        (cfg_shift),
    .meas_start       (meas_start),
    .valid_in         (valid_in),
    .i_in             (i_in),
    .q_in             (q_in),
    .valid_out        (valid_out),
    .i_out            (i_out),
    .q_out            (q_out),
    .start_count_out  (start_count_out),
    .finish_count_out (finish_count_out),
    .busy             (busy),
    .err_restart      (err_restart)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model: window phase, latched config, running sums.
  int     m_phase;   // 0 idle, 1 collecting, 2 finishing
  int     m_bl, m_nb, m_sh, m_cnt, m_bins;
  longint m_si, m_sq;
  bit     m_err;
  bit     exp_valid, exp_start, exp_finish;
  longint exp_i, exp_q;

  int obs_i[$];
  int obs_q[$];
  int obs_cyc[$];
  int obs_start[$];
  int fin_cyc[$];

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint ref_reduce(input longint s, input int sh);
    longint v;
    v = s >>> sh;
`ifdef READOUT_RX_BIN_INTEGRATOR_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`else
    v = v & 64'hFFFF;
    if (v >= 32768) v = v - 65536;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_err = 1'b0; m_cnt = 0; m_bins = 0; m_si = 0; m_sq = 0;
    exp_valid = 1'b0; exp_start = 1'b0; exp_finish = 1'b0;
  endtask

  task automatic model_step();
    exp_valid = 1'b0; exp_start = 1'b0; exp_finish = 1'b0;
    if (meas_start && m_phase != 0) m_err = 1'b1;
    case (m_phase)
      0: if (meas_start) begin
        m_bl = (cfg_bin_len == 0) ? 1 : int'(cfg_bin_len);
        m_nb = (cfg_num_bins == 0) ? 1 : int'(cfg_num_bins);
        m_sh = int'(cfg_shift);
        m_cnt = 0; m_bins = 0; m_si = 0; m_sq = 0; m_phase = 1;
      end
      1: if (valid_in) begin
        m_si += longint'(i_in); m_sq += longint'(q_in); m_cnt++;
        if (m_cnt == m_bl) begin
          exp_valid = 1'b1;
          exp_i = ref_reduce(m_si, m_sh);
          exp_q = ref_reduce(m_sq, m_sh);
          exp_start = (m_bins == 0);
          m_bins++; m_cnt = 0; m_si = 0; m_sq = 0;
          if (m_bins == m_nb) m_phase = 2;
        end
      end
      default: begin m_phase = 0; exp_finish = 1'b1; end
    endcase
  endtask

  // One clock: model consumes the same inputs as the DUT, then compare.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk($sformatf("valid_out@%0d", cyc), valid_out, exp_valid);
    chk($sformatf("start@%0d", cyc), start_count_out, exp_start);
    chk($sformatf("finish@%0d", cyc), finish_count_out, exp_finish);
    chk($sformatf("busy@%0d", cyc), busy, m_phase != 0);
    chk($sformatf("err_restart@%0d", cyc), err_restart, m_err);
    if (exp_valid) begin
      chk($sformatf("i_out@%0d", cyc), i_out, exp_i);
      chk($sformatf("q_out@%0d", cyc), q_out, exp_q);
    end
    if (valid_out === 1'b1) begin
      obs_i.push_back(int'(i_out)); obs_q.push_back(int'(q_out));
      obs_cyc.push_back(cyc); obs_start.push_back(int'(start_count_out));
    end
    if (finish_count_out === 1'b1) fin_cyc.push_back(cyc);
  endtask

  task automatic clear_obs();
    obs_i.delete(); obs_q.delete(); obs_cyc.delete(); obs_start.delete();
    fin_cyc.delete();
  endtask

  task automatic start_meas(input int bl, input int nb, input int sh);
    cfg_bin_len = 8'(bl); cfg_num_bins = 8'(nb); cfg_shift = 4'(sh);
    meas_start = 1'b1; valid_in = 1'b0;
    tick();
    meas_start = 1'b0;
  endtask

  task automatic sample(input bit v, input int iv, input int qv);
    valid_in = v; i_in = 16'(iv); q_in = 16'(qv);
    tick();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int c_last;

  initial begin
    model_reset();
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", valid_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_i", i_out, 0);
    chk("reset_err", err_restart, 0);
    rst = 1'b1;
    idle(2);

    // Basic window: two bins of four samples, shift 2
    clear_obs();
    start_meas(4, 2, 2);
    for (int k = 0; k < 8; k++) sample(1'b1, 100, -100);
    c_last = cyc;
    idle(3);
    chk("basic_nbins", obs_i.size(), 2);
    if (obs_i.size() == 2) begin
      chk("basic_i0", obs_i[0], 100);
      chk("basic_q0", obs_q[0], -100);
      chk("basic_i1", obs_i[1], 100);
      chk("basic_q1", obs_q[1], -100);
      chk("basic_start0", obs_start[0], 1);
      chk("basic_start1", obs_start[1], 0);
      chk("basic_latency", obs_cyc[1], c_last);
    end
    chk("basic_nfinish", fin_cyc.size(), 1);
    if (fin_cyc.size() == 1) chk("basic_finish_cyc", fin_cyc[0], c_last + 1);

    // Gaps in valid_in do not advance the sample count
    clear_obs();
    start_meas(3, 1, 0);
    sample(1'b1, 1, 0); sample(1'b0, 1, 0); sample(1'b1, 1, 0);
    sample(1'b0, 1, 0); sample(1'b0, 1, 0); sample(1'b1, 1, 0);
    c_last = cyc;
    idle(3);
    chk("gap_nbins", obs_i.size(), 1);
    if (obs_i.size() == 1) begin
      chk("gap_i", obs_i[0], 3);
      chk("gap_cyc", obs_cyc[0], c_last);
    end

    // Output range handling of a large bin sum
    clear_obs();
    start_meas(4, 1, 0);
    for (int k = 0; k < 4; k++) sample(1'b1, 30000, 0);
    idle(3);
    chk("sat_nbins", obs_i.size(), 1);
`ifdef READOUT_RX_BIN_INTEGRATOR_SAT_EN
    if (obs_i.size() == 1) chk("sat_i", obs_i[0], 32767);
`else
    if (obs_i.size() == 1) chk("wrap_i", obs_i[0], -11072);
`endif

    // Restart attempt mid-window: window unchanged, error sticky
    clear_obs();
    start_meas(2, 2, 0);
    sample(1'b1, 5, 5);
    cfg_bin_len = 8'd1; cfg_num_bins = 8'd1; cfg_shift = 4'd3;
    meas_start = 1'b1;
    sample(1'b1, 5, 5);
    meas_start = 1'b0;
    sample(1'b1, 5, 5); sample(1'b1, 5, 5);
    idle(4);
    chk("restart_nbins", obs_i.size(), 2);
    if (obs_i.size() == 2) begin
      chk("restart_i0", obs_i[0], 10);
      chk("restart_i1", obs_i[1], 10);
    end
    chk("restart_err", err_restart, 1);

    // Asynchronous reset after two of four samples
    clear_obs();
    start_meas(4, 1, 0);
    sample(1'b1, 50, 60); sample(1'b1, 50, 60);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_i", i_out, 0);
    chk("arst_err", err_restart, 0);
    model_reset();
    @(posedge clk); cyc++;
    #1;
    rst = 1'b1;
    sample(1'b1, 50, 60); sample(1'b1, 50, 60);
    idle(3);
    chk("arst_nfinish", fin_cyc.size(), 0);
    chk("arst_nbins", obs_i.size(), 0);

    // Zero configuration means one single-sample bin
    clear_obs();
    start_meas(0, 0, 0);
    sample(1'b1, 7, -3);
    c_last = cyc;
    idle(2);
    sample(1'b1, 9, 9);
    idle(2);
    chk("zero_nbins", obs_i.size(), 1);
    if (obs_i.size() == 1) begin
      chk("zero_i", obs_i[0], 7);
      chk("zero_q", obs_q[0], -3);
    end
    chk("zero_nfinish", fin_cyc.size(), 1);
    if (fin_cyc.size() == 1) chk("zero_finish_cyc", fin_cyc[0], c_last + 1);

    // Randomized windows with mid-window config churn and stray starts
    for (int w = 0; w < 40; w++) begin
      start_meas(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 15)));
      for (int k = 0; k < 300 && m_phase != 0; k++) begin
        cfg_bin_len  = 8'($urandom_range(0, 255));
        cfg_num_bins = 8'($urandom_range(0, 255));
        cfg_shift    = 4'($urandom_range(0, 15));
        meas_start   = ($urandom_range(0, 99) < 3);
        valid_in     = ($urandom_range(0, 9) < 7);
        i_in         = 16'($urandom);
        q_in         = 16'($urandom);
        tick();
        meas_start   = 1'b0;
      end
      valid_in = 1'b0;
      idle(int'($urandom_range(0, 2)));
      chk($sformatf("rand_idle_w%0d", w), busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
